// File: rtl/serial_adder.sv
// serial_adder: bit-serial unsigned adder with a valid/ready handshake on both sides.
// Operands are latched on acceptance. One bit pair is added per cycle, LSB first.
// The result is held until the consumer takes it.
// Optional build macro SERIAL_ADDER_SUB_EN adds a 'sub' input.
// When sub=1 the block computes a - b as a + ~b + 1, and carry=1 then means no borrow.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry
`ifdef SERIAL_ADDER_SUB_EN
  ,
  input  logic             sub
`endif
);

  localparam int unsigned    CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [CW-1:0]    cnt;
  logic             bit_sum;
  logic             bit_carry;

  // Full adder on the current LSBs; 'carry' doubles as the running carry flop
  always_comb begin
    bit_sum   = a_sh[0] ^ b_sh[0] ^ carry;
    bit_carry = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));
  end

  // Handshake FSM, operand shifters, bit counter and result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      a_sh      <= '0;
      b_sh      <= '0;
      cnt       <= '0;
      sum       <= '0;
      carry     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh     <= a;
`ifdef SERIAL_ADDER_SUB_EN
            // Subtraction: invert b once here and preset the carry to supply the +1
            b_sh     <= sub ? ~b : b;
            carry    <= sub;
`else
            b_sh     <= b;
            carry    <= 1'b0;
`endif
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= BUSY;
          end
        end
        BUSY: begin
          a_sh  <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
          sum   <= {bit_sum, sum[WIDTH-1:1]};
          carry <= bit_carry;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST) begin
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: scoreboard bench for serial_adder at WIDTH=8.
// When built with SERIAL_ADDER_SUB_EN, the bench also exercises subtraction.
module tb_serial_adder;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         carry;
`ifdef SERIAL_ADDER_SUB_EN
  logic         sub;
`endif

  int unsigned  checks;
  int unsigned  errors;
  logic [W:0]   exp_q[$];

  serial_adder #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .carry    (carry)
`ifdef SERIAL_ADDER_SUB_EN
    ,
    .sub      (sub)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference model: {carry, sum} for a + b, or a + ~b + 1 when subtracting
  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    logic [W-1:0] yy;
    yy = s ? ~y : y;
    return {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, s};
  endfunction

  task automatic accept(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic ts);
    int n;
    n = 0;
    while (!in_ready && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) check("accept_timeout", 32'(in_ready), 32'd1);
    a        = ta;
    b        = tb_;
`ifdef SERIAL_ADDER_SUB_EN
    sub      = ts;
`endif
    in_valid = 1'b1;
    @(posedge clk);
    exp_q.push_back(model(ta, tb_, ts));
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic check_result(input string tag);
    logic [W:0] e;
    check({tag, "_qsize"}, 32'(exp_q.size()), 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, "_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_sum"}, 32'(sum), 32'(e[W-1:0]));
      check({tag, "_carry"}, 32'(carry), 32'(e[W]));
    end
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_idle_rdy"}, 32'(in_ready), 32'd1);
    check({tag, "_idle_vld"}, 32'(out_valid), 32'd0);
  endtask

  task automatic quiet_cycles(input string tag, input int n);
    int seen;
    seen = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check({tag, "_spurious"}, 32'(seen), 32'd0);
  endtask

  initial begin
    int lat;
    int cyc;
    int last;
    int got;
    logic rdy;
    logic vld;
    logic [W:0] e;

    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
`ifdef SERIAL_ADDER_SUB_EN
    sub       = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_carry", 32'(carry), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // zero operands, latency from acceptance
    accept(8'h00, 8'h00, 1'b0);
    check("zero_busy_rdy", 32'(in_ready), 32'd0);
    wait_result(lat);
    check("zero_latency", 32'(lat), 32'(W));
    check_result("zero");
    consume("zero");

    // overflow to carry, result held while out_ready=0
    accept(8'hFF, 8'h01, 1'b0);
    wait_result(lat);
    check("ovf_latency", 32'(lat), 32'(W));
    check_result("ovf");
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("ovf_hold_vld", 32'(out_valid), 32'd1);
      check("ovf_hold_sum", 32'(sum), 32'h00);
      check("ovf_hold_carry", 32'(carry), 32'd1);
    end
    consume("ovf");

    // operand churn, in_valid and out_ready pulses while busy
    accept(8'h5A, 8'h3C, 1'b0);
    lat = 0;
    while (!out_valid && lat < 40) begin
      a         = W'($urandom);
      b         = W'($urandom);
      in_valid  = lat[0];
      out_ready = ~lat[0];
      @(posedge clk); #1;
      lat++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("churn_latency", 32'(lat), 32'(W));
    check_result("churn");
    consume("churn");
    quiet_cycles("churn", 12);

    // all-ones operands, reset in the 4th busy cycle
    accept(8'hFF, 8'hFF, 1'b0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_sum", 32'(sum), 32'd0);
    check("abort_carry", 32'(carry), 32'd0);
    exp_q.delete();
    quiet_cycles("abort", 12);
    accept(8'h01, 8'h02, 1'b0);
    wait_result(lat);
    check_result("after_abort");
    consume("after_abort");

    // all-ones plus all-ones, run to completion
    accept(8'hFF, 8'hFF, 1'b0);
    wait_result(lat);
    check_result("allones");
    consume("allones");

`ifdef SERIAL_ADDER_SUB_EN
    accept(8'h10, 8'h01, 1'b1);
    wait_result(lat);
    check_result("sub_noborrow");
    consume("sub_noborrow");
    accept(8'h01, 8'h02, 1'b1);
    wait_result(lat);
    check_result("sub_borrow");
    consume("sub_borrow");
    sub = 1'b0;
`endif

    // back-to-back: in_valid and out_ready held high
    a         = W'($urandom);
    b         = W'($urandom);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    cyc       = 0;
    last      = -1;
    got       = 0;
    while (got < 6 && cyc < 200) begin
      rdy = in_ready;
      vld = out_valid;
      if (vld) begin
        check("b2b_qsize", 32'(exp_q.size()), 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("b2b_sum", 32'(sum), 32'(e[W-1:0]));
          check("b2b_carry", 32'(carry), 32'(e[W]));
        end
        if (last >= 0) check("b2b_interval", 32'(cyc - last), 32'(W + 2));
        last = cyc;
        got++;
      end
      @(posedge clk);
      if (rdy) exp_q.push_back(model(a, b, 1'b0));
      #1;
      cyc++;
      if (rdy) begin
        a = W'($urandom);
        b = W'($urandom);
      end
      if (vld) check("b2b_rdy_after_done", 32'(in_ready), 32'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("b2b_count", 32'(got), 32'd6);
    check("b2b_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
